dmem_responder: RTL and testbench

- Multi-cycle data-memory responder: the memory end of the CPU load/store interface, replacing the combinational data-memory model.
- Accepts one read or write request at a time, waits a fixed LATENCY, then returns a one-cycle response with read data or an error flag.
- Word-addressed internal array.
- The CPU side stalls while ready_o is low.

---
 rtl/dmem_responder.sv | 125 ++++++++++++
 tb/tb_dmem_responder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one request at a time, fixed-latency response.
// Latency: valid_o rises LATENCY cycles after the accept cycle; ready_o returns the cycle after.
// Backpressure: ready_o is high only in IDLE, and request inputs are ignored while it is low.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        memread_i,
  input  logic        memwrite_i,
  input  logic [31:0] address_i,
  input  logic [31:0] write_data_i,
  output logic        ready_o,
  output logic        valid_o,
  output logic        err_o,
  output logic [31:0] read_data_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q;
  logic        rd_q, wr_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic          accept;
  logic          enter_resp;
  logic [31:0]   cur_addr, cur_wdata;
  logic          cur_rd, cur_wr, cur_err;
  logic [AW-1:0] cur_idx;
  logic          do_write, do_read;

  assign accept = (state_q == S_IDLE) && (memread_i || memwrite_i);

  // The request being committed: the live inputs when RESP is entered straight
  // from IDLE (LATENCY=1), otherwise the copy latched at accept time.
  always_comb begin
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    cur_rd    = rd_q;
    cur_wr    = wr_q;
    if (state_q == S_IDLE) begin
      cur_addr  = address_i;
      cur_wdata = write_data_i;
      cur_rd    = memread_i;
      cur_wr    = memwrite_i;
    end
  end

  // Misaligned, out of range, or simultaneous read and write are all errors.
  assign cur_err = (cur_addr[1:0] != 2'b00)
                || ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS))
                || (cur_rd && cur_wr);
  assign cur_idx    = cur_addr[AW+1:2];
  assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
  assign do_write   = enter_resp && cur_wr && !cur_err;
  assign do_read    = enter_resp && cur_rd && !cur_err;

  // Next-state logic: WAIT counts down and hands over to RESP when the count hits 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter, latched request and response registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= address_i;
        wdata_q <= write_data_i;
        rd_q    <= memread_i;
        wr_q    <= memwrite_i;
      end
      if (enter_resp) err_q <= cur_err;
      if (enter_resp && cur_err) rdata_q <= 32'd0;
      else if (do_read)          rdata_q <= mem_q[cur_idx];
    end
  end

  // Array write; contents survive reset, but a write never commits while reset is held.
  always_ff @(posedge clk_i) begin
    if (do_write && !rst_i) mem_q[cur_idx] <= cur_wdata;
  end

  assign ready_o     = (state_q == S_IDLE);
  assign valid_o     = (state_q == S_RESP);
  assign err_o       = (state_q == S_RESP) && err_q;
  assign read_data_o = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance at LATENCY=2 (u2) and one at LATENCY=1 (u1).
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd2, wr2, rd1, wr1;
  logic [31:0] addr, wdat;
  logic        r2, v2, e2, r1, v1, e1;
  logic [31:0] d2, d1;
  int cmp = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u2 (
    .clk_i(clk), .rst_i(rst), .memread_i(rd2), .memwrite_i(wr2),
    .address_i(addr), .write_data_i(wdat),
    .ready_o(r2), .valid_o(v2), .err_o(e2), .read_data_o(d2));

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u1 (
    .clk_i(clk), .rst_i(rst), .memread_i(rd1), .memwrite_i(wr1),
    .address_i(addr), .write_data_i(wdat),
    .ready_o(r1), .valid_o(v1), .err_o(e1), .read_data_o(d1));

  // One request on the selected instance (sel=1 -> u1); returns cycles to valid (-1 on timeout)
  // and the outputs seen in the response cycle.
  task automatic xact(input bit sel, input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] w, output int lat, output logic [31:0] data,
                      output logic err, output logic rdy);
    @(negedge clk);
    addr = a; wdat = w;
    if (sel) begin rd1 = rd; wr1 = wr; end else begin rd2 = rd; wr2 = wr; end
    @(negedge clk);
    rd1 = 0; wr1 = 0; rd2 = 0; wr2 = 0;
    lat = 1;
    while (!(sel ? v1 : v2) && lat < 20) begin @(negedge clk); lat++; end
    if (!(sel ? v1 : v2)) lat = -1;
    data = sel ? d1 : d2;
    err  = sel ? e1 : e2;
    rdy  = sel ? r1 : r2;
  endtask

  task automatic test_reset();
    rst = 1;
    @(negedge clk); @(negedge clk);
    cmp++; if (r2 !== 1'b1) begin bad++; $display("FAIL rst_ready2: got %b want 1", r2); end
    cmp++; if (v2 !== 1'b0) begin bad++; $display("FAIL rst_valid2: got %b want 0", v2); end
    cmp++; if (e2 !== 1'b0) begin bad++; $display("FAIL rst_err2: got %b want 0", e2); end
    cmp++; if (d2 !== 32'h0) begin bad++; $display("FAIL rst_data2: got %h want 0", d2); end
    cmp++; if (r1 !== 1'b1) begin bad++; $display("FAIL rst_ready1: got %b want 1", r1); end
    cmp++; if (v1 !== 1'b0) begin bad++; $display("FAIL rst_valid1: got %b want 0", v1); end
    cmp++; if (d1 !== 32'h0) begin bad++; $display("FAIL rst_data1: got %h want 0", d1); end
    rst = 0;
  endtask

  task automatic test_read_latency();
    int lat; logic [31:0] d; logic e, r;
    xact(0, 0, 1, 32'h10, 32'hDEADBEEF, lat, d, e, r);
    cmp++; if (lat !== 2) begin bad++; $display("FAIL wr_lat: got %0d want 2", lat); end
    cmp++; if (e !== 1'b0) begin bad++; $display("FAIL wr_err: got %b want 0", e); end
    @(negedge clk);
    cmp++; if (r2 !== 1'b1) begin bad++; $display("FAIL c0_ready: got %b want 1", r2); end
    addr = 32'h10; rd2 = 1;
    @(negedge clk); rd2 = 0;
    cmp++; if (v2 !== 1'b0 || r2 !== 1'b0) begin bad++; $display("FAIL c1_vr: got v=%b r=%b want v=0 r=0", v2, r2); end
    @(negedge clk);
    cmp++; if (v2 !== 1'b1 || r2 !== 1'b0) begin bad++; $display("FAIL c2_vr: got v=%b r=%b want v=1 r=0", v2, r2); end
    cmp++; if (d2 !== 32'hDEADBEEF) begin bad++; $display("FAIL c2_data: got %h want deadbeef", d2); end
    cmp++; if (e2 !== 1'b0) begin bad++; $display("FAIL c2_err: got %b want 0", e2); end
    @(negedge clk);
    cmp++; if (r2 !== 1'b1 || v2 !== 1'b0) begin bad++; $display("FAIL c3_rv: got r=%b v=%b want r=1 v=0", r2, v2); end
    cmp++; if (d2 !== 32'hDEADBEEF) begin bad++; $display("FAIL c3_hold: got %h want deadbeef", d2); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] d; logic e, r;
    xact(1, 0, 1, 32'h0, 32'h11111111, lat, d, e, r);
    cmp++; if (lat !== 1 || r !== 1'b0) begin bad++; $display("FAIL b2b_w0: got lat=%0d rdy=%b want 1/0", lat, r); end
    cmp++; if (d !== 32'h0) begin bad++; $display("FAIL b2b_w0_hold: got %h want 0", d); end
    xact(1, 0, 1, 32'h4, 32'h22222222, lat, d, e, r);
    cmp++; if (lat !== 1 || r !== 1'b0) begin bad++; $display("FAIL b2b_w4: got lat=%0d rdy=%b want 1/0", lat, r); end
    xact(1, 1, 0, 32'h0, 32'h0, lat, d, e, r);
    cmp++; if (lat !== 1 || r !== 1'b0 || e !== 1'b0) begin bad++; $display("FAIL b2b_r0: got lat=%0d rdy=%b err=%b want 1/0/0", lat, r, e); end
    cmp++; if (d !== 32'h11111111) begin bad++; $display("FAIL b2b_r0_data: got %h want 11111111", d); end
    xact(1, 1, 0, 32'h4, 32'h0, lat, d, e, r);
    cmp++; if (lat !== 1 || r !== 1'b0) begin bad++; $display("FAIL b2b_r4: got lat=%0d rdy=%b want 1/0", lat, r); end
    cmp++; if (d !== 32'h22222222) begin bad++; $display("FAIL b2b_r4_data: got %h want 22222222", d); end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] d; logic e, r;
    xact(0, 0, 1, 32'h8, 32'h12345678, lat, d, e, r);
    cmp++; if (e !== 1'b0 || d !== 32'hDEADBEEF) begin bad++; $display("FAIL err_wr8: got err=%b data=%h want 0/deadbeef", e, d); end
    xact(0, 1, 0, 32'h6, 32'h0, lat, d, e, r);
    cmp++; if (lat !== 2 || e !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL err_mis: got lat=%0d err=%b data=%h want 2/1/0", lat, e, d); end
    @(negedge clk);
    cmp++; if (e2 !== 1'b0 || v2 !== 1'b0) begin bad++; $display("FAIL err_clear: got err=%b v=%b want 0/0", e2, v2); end
    xact(0, 1, 0, 32'h400, 32'h0, lat, d, e, r);
    cmp++; if (e !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL err_oor: got err=%b data=%h want 1/0", e, d); end
    xact(0, 1, 1, 32'h8, 32'hFFFFFFFF, lat, d, e, r);
    cmp++; if (e !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL err_both: got err=%b data=%h want 1/0", e, d); end
    xact(0, 1, 0, 32'h8, 32'h0, lat, d, e, r);
    cmp++; if (e !== 1'b0 || d !== 32'h12345678) begin bad++; $display("FAIL err_rb8: got err=%b data=%h want 0/12345678", e, d); end
    xact(0, 0, 1, 32'h3FC, 32'h55AA55AA, lat, d, e, r);
    xact(0, 1, 0, 32'h3FC, 32'h0, lat, d, e, r);
    cmp++; if (e !== 1'b0 || d !== 32'h55AA55AA) begin bad++; $display("FAIL err_top: got err=%b data=%h want 0/55aa55aa", e, d); end
  endtask

  task automatic test_reset_abort();
    int lat; int vcnt; logic [31:0] d; logic e, r;
    xact(0, 0, 1, 32'h20, 32'h0BADF00D, lat, d, e, r);
    @(negedge clk);
    addr = 32'h20; wdat = 32'hCAFEF00D; wr2 = 1;
    @(negedge clk); wr2 = 0;
    cmp++; if (r2 !== 1'b0 || v2 !== 1'b0) begin bad++; $display("FAIL abort_wait: got r=%b v=%b want 0/0", r2, v2); end
    rst = 1; #1;
    cmp++; if (r2 !== 1'b1 || v2 !== 1'b0) begin bad++; $display("FAIL abort_rst: got r=%b v=%b want 1/0", r2, v2); end
    @(negedge clk); rst = 0;
    vcnt = 0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); if (v2) vcnt++; end
    cmp++; if (vcnt !== 0) begin bad++; $display("FAIL abort_novalid: got %0d responses want 0", vcnt); end
    xact(0, 1, 0, 32'h20, 32'h0, lat, d, e, r);
    cmp++; if (e !== 1'b0 || d !== 32'h0BADF00D) begin bad++; $display("FAIL abort_rb: got err=%b data=%h want 0/0badf00d", e, d); end
  endtask

  task automatic test_ignored();
    int lat; logic [31:0] d; logic e, r;
    xact(0, 0, 1, 32'h34, 32'h34343434, lat, d, e, r);
    @(negedge clk);
    addr = 32'h30; wdat = 32'hA5A5A5A5; wr2 = 1;
    @(negedge clk);
    wr2 = 0; rd2 = 1; addr = 32'h34; wdat = 32'hFFFF0000;
    @(negedge clk); rd2 = 0;
    cmp++; if (v2 !== 1'b1 || e2 !== 1'b0 || d2 !== 32'h0BADF00D) begin bad++; $display("FAIL ign_resp: got v=%b err=%b data=%h want 1/0/0badf00d", v2, e2, d2); end
    xact(0, 1, 0, 32'h30, 32'h0, lat, d, e, r);
    cmp++; if (d !== 32'hA5A5A5A5) begin bad++; $display("FAIL ign_r30: got %h want a5a5a5a5", d); end
    xact(0, 1, 0, 32'h34, 32'h0, lat, d, e, r);
    cmp++; if (d !== 32'h34343434) begin bad++; $display("FAIL ign_r34: got %h want 34343434", d); end
    xact(0, 1, 0, 32'h10, 32'h0, lat, d, e, r);
    cmp++; if (d !== 32'hDEADBEEF) begin bad++; $display("FAIL ign_r10: got %h want deadbeef", d); end
  endtask

  task automatic test_held();
    logic [9:0] vmask, rmask; int dbad;
    vmask = '0; rmask = '0; dbad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vmask[c] = v2; rmask[c] = r2;
      if (v2 && d2 !== 32'hDEADBEEF) dbad++;
      addr = 32'h10; rd2 = (c < 9);
    end
    rd2 = 0;
    cmp++; if (vmask !== 10'h124) begin bad++; $display("FAIL held_valid: got %b want 0100100100", vmask); end
    cmp++; if (rmask !== 10'h249) begin bad++; $display("FAIL held_ready: got %b want 1001001001", rmask); end
    cmp++; if (dbad !== 0) begin bad++; $display("FAIL held_data: got %0d bad reads want 0", dbad); end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rst = 1; rd2 = 0; wr2 = 0; rd1 = 0; wr1 = 0; addr = '0; wdat = '0;
    test_reset();
    test_read_latency();
    test_back_to_back();
    test_errors();
    test_reset_abort();
    test_ignored();
    test_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
